dispatch_credit: RTL and testbench

DISPATCH_CREDIT -- requirements
Module: dispatch_credit

---
 rtl/dispatch_credit.sv | 142 ++++++++++++++
 tb/tb_dispatch_credit.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/dispatch_credit.sv
// Credit-checked in-order dispatch: holds a rename bundle and allocates ROB/RS
// entries lane by lane while credits last.
module dispatch_credit #(
    parameter int WIDTH        = 2,
    parameter int ROB_DEPTH    = 16,
    parameter int ALU_RS_DEPTH = 8,
    parameter int BR_RS_DEPTH  = 4,
    parameter int LSU_RS_DEPTH = 8,
    localparam int RW  = $clog2(WIDTH + 1),
    localparam int RCW = $clog2(ROB_DEPTH + 1),
    localparam int ACW = $clog2(ALU_RS_DEPTH + 1),
    localparam int BCW = $clog2(BR_RS_DEPTH + 1),
    localparam int LCW = $clog2(LSU_RS_DEPTH + 1)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               flush,
    input  logic [WIDTH-1:0]   i_valid,
    input  logic [2*WIDTH-1:0] i_futype,
    output logic               o_ready,
    input  logic [RW-1:0]      rob_release,
    input  logic [RW-1:0]      alu_release,
    input  logic [RW-1:0]      br_release,
    input  logic [RW-1:0]      lsu_release,
    output logic [WIDTH-1:0]   rob_alloc,
    output logic [WIDTH-1:0]   alu_rs_alloc,
    output logic [WIDTH-1:0]   branch_rs_alloc,
    output logic [WIDTH-1:0]   lsu_rs_alloc,
    output logic [WIDTH-1:0]   o_held,
    output logic               o_credit_err
);

    logic [WIDTH-1:0]   held_q, held_d;
    logic [2*WIDTH-1:0] type_q, type_d;
    logic [RCW-1:0]     rob_q, rob_d;
    logic [ACW-1:0]     alu_q, alu_d;
    logic [BCW-1:0]     br_q, br_d;
    logic [LCW-1:0]     lsu_q, lsu_d;
    logic               err_q, err_d;

    logic [WIDTH-1:0]   disp;
    logic               chain, ok, accept;
    logic [1:0]         ft;
    int                 rc, ac, bc, lc;
    int                 rob_n, alu_n, br_n, lsu_n;

    function automatic int clip(input int n, input int d);
        return (n > d) ? d : n;
    endfunction

    // Lane walk: a stalled held lane breaks the chain for all higher lanes
    always_comb begin
        disp            = '0;
        rob_alloc       = '0;
        alu_rs_alloc    = '0;
        branch_rs_alloc = '0;
        lsu_rs_alloc    = '0;
        chain           = 1'b1;
        ok              = 1'b0;
        ft              = 2'b00;
        rc = 0; ac = 0; bc = 0; lc = 0;
        for (int k = 0; k < WIDTH; k++) begin
            ft = type_q[2*k +: 2];
            if (held_q[k] && chain) begin
                ok = int'(rob_q) > rc;
                case (ft)
                    2'b00:   ok = ok && (int'(alu_q) > ac);
                    2'b01:   ok = ok && (int'(br_q) > bc);
                    2'b10:   ok = ok && (int'(lsu_q) > lc);
                    default: ok = ok;
                endcase
                if (ok) begin
                    disp[k]      = 1'b1;
                    rob_alloc[k] = 1'b1;
                    rc++;
                    case (ft)
                        2'b00:   begin alu_rs_alloc[k] = 1'b1; ac++; end
                        2'b01:   begin branch_rs_alloc[k] = 1'b1; bc++; end
                        2'b10:   begin lsu_rs_alloc[k] = 1'b1; lc++; end
                        default: ;
                    endcase
                end else begin
                    chain = 1'b0;
                end
            end
        end
        if (rst || flush) begin
            disp            = '0;
            rob_alloc       = '0;
            alu_rs_alloc    = '0;
            branch_rs_alloc = '0;
            lsu_rs_alloc    = '0;
        end
    end

    assign o_ready = !rst && !flush && ((held_q & ~disp) == '0);
    assign accept  = o_ready && (|i_valid);
    assign o_held       = held_q;
    assign o_credit_err = err_q;

    always_comb begin
        held_d = held_q & ~disp;
        type_d = type_q;
        if (flush) begin
            held_d = '0;
        end else if (accept) begin
            held_d = i_valid;
            type_d = i_futype;
        end
        rob_n = int'(rob_q) - $countones(rob_alloc) + int'(rob_release);
        alu_n = int'(alu_q) - $countones(alu_rs_alloc) + int'(alu_release);
        br_n  = int'(br_q) - $countones(branch_rs_alloc) + int'(br_release);
        lsu_n = int'(lsu_q) - $countones(lsu_rs_alloc) + int'(lsu_release);
        rob_d = RCW'(clip(rob_n, ROB_DEPTH));
        alu_d = ACW'(clip(alu_n, ALU_RS_DEPTH));
        br_d  = BCW'(clip(br_n, BR_RS_DEPTH));
        lsu_d = LCW'(clip(lsu_n, LSU_RS_DEPTH));
        err_d = err_q || (rob_n > ROB_DEPTH) || (alu_n > ALU_RS_DEPTH)
              || (br_n > BR_RS_DEPTH) || (lsu_n > LSU_RS_DEPTH);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            held_q <= '0;
            type_q <= '0;
            rob_q  <= RCW'(ROB_DEPTH);
            alu_q  <= ACW'(ALU_RS_DEPTH);
            br_q   <= BCW'(BR_RS_DEPTH);
            lsu_q  <= LCW'(LSU_RS_DEPTH);
            err_q  <= 1'b0;
        end else begin
            held_q <= held_d;
            type_q <= type_d;
            rob_q  <= rob_d;
            alu_q  <= alu_d;
            br_q   <= br_d;
            lsu_q  <= lsu_d;
            err_q  <= err_d;
        end
    end

endmodule

// File: tb/tb_dispatch_credit.sv
// Directed bench for dispatch_credit with small credit pools.
module tb_dispatch_credit;

    localparam int W = 2;

    logic         clk = 1'b0;
    logic         rst, flush;
    logic [1:0]   i_valid;
    logic [3:0]   i_futype;
    logic         o_ready;
    logic [1:0]   rob_release, alu_release, br_release, lsu_release;
    logic [1:0]   rob_alloc, alu_rs_alloc, branch_rs_alloc, lsu_rs_alloc;
    logic [1:0]   o_held;
    logic         o_credit_err;

    int n_tests = 0;
    int n_fail  = 0;

    dispatch_credit #(
        .WIDTH(W), .ROB_DEPTH(4), .ALU_RS_DEPTH(2),
        .BR_RS_DEPTH(1), .LSU_RS_DEPTH(2)
    ) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .i_valid(i_valid), .i_futype(i_futype), .o_ready(o_ready),
        .rob_release(rob_release), .alu_release(alu_release),
        .br_release(br_release), .lsu_release(lsu_release),
        .rob_alloc(rob_alloc), .alu_rs_alloc(alu_rs_alloc),
        .branch_rs_alloc(branch_rs_alloc), .lsu_rs_alloc(lsu_rs_alloc),
        .o_held(o_held), .o_credit_err(o_credit_err)
    );

    always #5 clk = ~clk;

    // {rob, alu, br, lsu} strobes packed for compact comparison
    wire [7:0] strb = {rob_alloc, alu_rs_alloc, branch_rs_alloc, lsu_rs_alloc};
    wire [8:0] creds = {dut.rob_q, dut.alu_q, dut.br_q, dut.lsu_q};

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        flush = 0; i_valid = 0; i_futype = 0;
        rob_release = 0; alu_release = 0;
        br_release = 0; lsu_release = 0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1;
        tick();
        tick();
        rst = 0;
        tick();
    endtask

    task automatic test_reset();
        idle_inputs();
        rst = 1;
        i_valid = 2'b11;
        tick();
        tick();
        n_tests++;
        if (o_ready !== 1'b0 || strb !== 8'h00) begin
            n_fail++;
            $display("FAIL rst_hold: ready=%b strb=%h need 0/00", o_ready, strb);
        end
        i_valid = 0;
        rst = 0;
        tick();
        n_tests++;
        if (o_ready !== 1'b1 || o_held !== 2'b00 || o_credit_err !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_out: ready=%b held=%b err=%b need 1/00/0",
                     o_ready, o_held, o_credit_err);
        end
        n_tests++;
        if (creds !== {3'd4, 2'd2, 1'd1, 2'd2}) begin
            n_fail++;
            $display("FAIL rst_creds: got %h need %h", creds, {3'd4, 2'd2, 1'd1, 2'd2});
        end
    endtask

    task automatic test_alu_pair();
        do_reset();
        i_valid = 2'b11; i_futype = 4'b0000;
        tick();
        idle_inputs();
        n_tests++;
        if (strb !== 8'b11_11_00_00 || o_held !== 2'b11) begin
            n_fail++;
            $display("FAIL alu_pair_strb: strb=%b held=%b need 11110000/11", strb, o_held);
        end
        tick();
        n_tests++;
        if (dut.alu_q !== 2'd0 || dut.rob_q !== 3'd2 || o_held !== 2'b00) begin
            n_fail++;
            $display("FAIL alu_pair_cred: alu=%0d rob=%0d held=%b need 0/2/00",
                     dut.alu_q, dut.rob_q, o_held);
        end
    endtask

    task automatic test_br_stall();
        do_reset();
        i_valid = 2'b11; i_futype = 4'b0101;
        tick();
        idle_inputs();
        n_tests++;
        if (strb !== 8'b01_00_01_00 || o_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL br_first: strb=%b ready=%b need 01000100/0", strb, o_ready);
        end
        tick();
        br_release = 2'd1;
        #1;
        n_tests++;
        if (o_held !== 2'b10 || o_ready !== 1'b0 || strb !== 8'h00) begin
            n_fail++;
            $display("FAIL br_wait: held=%b ready=%b strb=%h need 10/0/00",
                     o_held, o_ready, strb);
        end
        tick();
        br_release = 0;
        #1;
        n_tests++;
        if (strb !== 8'b10_00_10_00 || o_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL br_second: strb=%b ready=%b need 10001000/1", strb, o_ready);
        end
        tick();
        n_tests++;
        if (o_held !== 2'b00 || dut.br_q !== 1'd0 || dut.rob_q !== 3'd2) begin
            n_fail++;
            $display("FAIL br_done: held=%b br=%0d rob=%0d need 00/0/2",
                     o_held, dut.br_q, dut.rob_q);
        end
    endtask

    task automatic test_in_order();
        do_reset();
        i_valid = 2'b11; i_futype = 4'b0000;
        tick();
        idle_inputs();
        tick();
        i_valid = 2'b11; i_futype = 4'b1000;
        tick();
        idle_inputs();
        alu_release = 2'd1;
        #1;
        n_tests++;
        if (o_held !== 2'b11 || strb !== 8'h00 || o_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL inorder_block: held=%b strb=%h ready=%b need 11/00/0",
                     o_held, strb, o_ready);
        end
        tick();
        alu_release = 0;
        #1;
        n_tests++;
        if (strb !== 8'b11_01_00_10) begin
            n_fail++;
            $display("FAIL inorder_go: strb=%b need 11010010", strb);
        end
    endtask

    task automatic test_rob_only();
        do_reset();
        i_valid = 2'b01; i_futype = 4'b0111;
        tick();
        idle_inputs();
        n_tests++;
        if (strb !== 8'b01_00_00_00 || o_held !== 2'b01) begin
            n_fail++;
            $display("FAIL rob_only: strb=%b held=%b need 01000000/01", strb, o_held);
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        i_valid = 2'b11; i_futype = 4'b1111;
        tick();
        i_valid = 2'b01; i_futype = 4'b0010;
        #1;
        n_tests++;
        if (o_ready !== 1'b1 || strb !== 8'b11_00_00_00) begin
            n_fail++;
            $display("FAIL b2b_first: ready=%b strb=%b need 1/11000000", o_ready, strb);
        end
        tick();
        idle_inputs();
        n_tests++;
        if (o_held !== 2'b01 || strb !== 8'b01_00_00_01) begin
            n_fail++;
            $display("FAIL b2b_second: held=%b strb=%b need 01/01000001", o_held, strb);
        end
    endtask

    task automatic test_flush();
        do_reset();
        i_valid = 2'b11; i_futype = 4'b0000;
        tick();
        idle_inputs();
        tick();
        i_valid = 2'b11; i_futype = 4'b0000;
        tick();
        idle_inputs();
        flush = 1;
        alu_release = 2'd1;
        i_valid = 2'b11;
        #1;
        n_tests++;
        if (strb !== 8'h00 || o_ready !== 1'b0 || o_held !== 2'b11) begin
            n_fail++;
            $display("FAIL flush_during: strb=%h ready=%b held=%b need 00/0/11",
                     strb, o_ready, o_held);
        end
        tick();
        idle_inputs();
        #1;
        n_tests++;
        if (o_held !== 2'b00 || o_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL flush_after: held=%b ready=%b need 00/1", o_held, o_ready);
        end
        n_tests++;
        if (dut.alu_q !== 2'd1 || dut.rob_q !== 3'd2) begin
            n_fail++;
            $display("FAIL flush_cred: alu=%0d rob=%0d need 1/2", dut.alu_q, dut.rob_q);
        end
    endtask

    task automatic test_overflow();
        do_reset();
        rob_release = 2'd1;
        #1;
        n_tests++;
        if (o_credit_err !== 1'b0) begin
            n_fail++;
            $display("FAIL ovf_pre: err=%b need 0", o_credit_err);
        end
        tick();
        rob_release = 0;
        tick();
        tick();
        n_tests++;
        if (o_credit_err !== 1'b1 || dut.rob_q !== 3'd4) begin
            n_fail++;
            $display("FAIL ovf_sticky: err=%b rob=%0d need 1/4", o_credit_err, dut.rob_q);
        end
        do_reset();
        n_tests++;
        if (o_credit_err !== 1'b0) begin
            n_fail++;
            $display("FAIL ovf_clear: err=%b need 0", o_credit_err);
        end
    endtask

    initial begin
        idle_inputs();
        rst = 1;
        test_reset();
        test_alu_pair();
        test_br_stall();
        test_in_order();
        test_rob_only();
        test_back_to_back();
        test_flush();
        test_overflow();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
